// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Operands are resolved through two-level
// forwarding when captured, and register-sourced operands are re-patched while stalled.
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RAW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       in_op,
  input  logic [RAW-1:0]   in_rs_addr,
  input  logic [RAW-1:0]   in_rt_addr,
  input  logic [RAW-1:0]   in_rd_addr,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic [15:0]      in_imm,
  input  logic             in_imm_sext,
  input  logic             in_use_imm,
  input  logic [4:0]       in_shamt,
  input  logic             in_use_shamt,
  input  logic             in_we,
  input  logic             fwd1_we,
  input  logic [RAW-1:0]   fwd1_rd,
  input  logic [WIDTH-1:0] fwd1_data,
  input  logic             fwd2_we,
  input  logic [RAW-1:0]   fwd2_rd,
  input  logic [WIDTH-1:0] fwd2_data,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [RAW-1:0]   ex_rd,
  output logic             ex_we,
  output logic             ex_valid
);

  logic [3:0]       op_q,        op_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [RAW-1:0]   rd_q,        rd_d;
  logic             we_q,        we_d;
  logic             valid_q,     valid_d;
  logic [RAW-1:0]   rs_addr_q,   rs_addr_d;
  logic [RAW-1:0]   rt_addr_q,   rt_addr_d;
  logic             use_shamt_q, use_shamt_d;
  logic             use_imm_q,   use_imm_d;

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] shamt_ext;

  // Newest matching in-flight result for a nonzero register, else the fallback value.
  function automatic logic [WIDTH-1:0] forward(input logic [RAW-1:0]   addr,
                                               input logic [WIDTH-1:0] fallback);
    if (addr == '0)                      forward = fallback;
    else if (fwd1_we && fwd1_rd == addr) forward = fwd1_data;
    else if (fwd2_we && fwd2_rd == addr) forward = fwd2_data;
    else                                 forward = fallback;
  endfunction

  function automatic logic [WIDTH-1:0] resolve(input logic [RAW-1:0]   addr,
                                               input logic [WIDTH-1:0] rf_data);
    resolve = (addr == '0) ? '0 : forward(addr, rf_data);
  endfunction

  assign imm_ext   = in_imm_sext ? {{(WIDTH-16){in_imm[15]}}, in_imm}
                                 : {{(WIDTH-16){1'b0}}, in_imm};
  assign shamt_ext = {{(WIDTH-5){1'b0}}, in_shamt};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    we_d        = we_q;
    valid_d     = valid_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    use_shamt_d = use_shamt_q;
    use_imm_d   = use_imm_q;

    if (flush || (!stall && !in_valid)) begin
      // Bubbles also drop their source addresses so a later stall never patches them.
      op_d        = '0;
      a_d         = '0;
      b_d         = '0;
      rd_d        = '0;
      we_d        = 1'b0;
      valid_d     = 1'b0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      use_shamt_d = 1'b0;
      use_imm_d   = 1'b0;
    end else if (stall) begin
      if (!use_shamt_q) a_d = forward(rs_addr_q, a_q);
      if (!use_imm_q)   b_d = forward(rt_addr_q, b_q);
    end else begin
      op_d        = in_op;
      a_d         = in_use_shamt ? shamt_ext : resolve(in_rs_addr, in_rs_data);
      b_d         = in_use_imm   ? imm_ext   : resolve(in_rt_addr, in_rt_data);
      rd_d        = in_rd_addr;
      we_d        = in_we;
      valid_d     = 1'b1;
      rs_addr_d   = in_rs_addr;
      rt_addr_d   = in_rt_addr;
      use_shamt_d = in_use_shamt;
      use_imm_d   = in_use_imm;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      use_shamt_q <= 1'b0;
      use_imm_q   <= 1'b0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      valid_q     <= valid_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      use_shamt_q <= use_shamt_d;
      use_imm_q   <= use_imm_d;
    end
  end

  assign alu_op   = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign ex_rd    = rd_q;
  assign ex_we    = we_q;
  assign ex_valid = valid_q;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register for the 32-bit MIPS datapath. It registers decoded instructions and drives the `OP`/`A`/`B` inputs of the ALU directly. Register operands are resolved through two-level forwarding at capture time. Held operands are re-patched from forwarding sources while the stage is stalled. It also supplies the immediate extension and shift-amount routing the ALU encodings require.

## Interface
- `WIDTH`, 32, datapath width
- `RAW`, 5, register-address width
- `clk` input 1: clock; one clock domain, all state on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `stall` input 1: hold current contents
- `flush` input 1: replace contents with bubble
- `in_valid` input 1: decode slot holds an instruction
- `in_op` input 4: ALU code (AND 0, OR 1, XOR 2, NOR 3, ADD 4, SUB 5, SLT 6, SLL 7)
- `in_rs_addr`, `in_rt_addr`, `in_rd_addr` input RAW: source/destination registers
- `in_rs_data`, `in_rt_data` input WIDTH: register-file read data
- `in_imm` input 16: raw immediate
- `in_imm_sext` input 1: 1 = sign-extend imm, 0 = zero-extend
- `in_use_imm` input 1: B operand = extended imm instead of rt
- `in_shamt` input 5: shift amount
- `in_use_shamt` input 1: A operand = zero-extended shamt instead of rs
- `in_we` input 1: instruction writes `in_rd_addr`
- `fwd1_we`, `fwd1_rd`, `fwd1_data` input 1/RAW/WIDTH: newest result (instruction now in EX, ALU `F`)
- `fwd2_we`, `fwd2_rd`, `fwd2_data` input 1/RAW/WIDTH: older result (MEM stage)
- `alu_op` output 4: to ALU `OP`
- `alu_a`, `alu_b` output WIDTH: to ALU `A`, `B`
- `ex_rd` output RAW, `ex_we` output 1, `ex_valid` output 1: destination info for downstream stages

## Operation
- Forward resolve(addr, rfdata):
  - if addr == 0, result is 0.
  - else if `fwd1_we` && `fwd1_rd` == addr, result is `fwd1_data`.
  - else if `fwd2_we` && `fwd2_rd` == addr, result is `fwd2_data`.
  - else result is rfdata.
  - fwd1 has priority over fwd2.
- Immediate extension:
  - `in_imm_sext` = 1: {16{imm[15]}, imm}.
  - `in_imm_sext` = 0: {16'b0, imm}.
- A operand:
  - `in_use_shamt` = 1: {27'b0, shamt}.
  - else resolve(rs).
- B operand:
  - `in_use_imm` = 1: extended imm.
  - else resolve(rt).
- SLL computes B<<A. Shift instructions therefore present the shift count on A and the value on B.
- Internal state: registered copies of rs/rt addresses, `use_shamt`, `use_imm` and the outputs. This state is used for stall patching.
- Per-cycle priority: `rst_n`=0 > `flush` > `stall` > load.
  - Reset: all outputs and internal state cleared to 0.
  - Flush: `ex_valid`=0, `ex_we`=0, `alu_op`=0, `alu_a`=`alu_b`=0, `ex_rd`=0. Applies even if `stall`=1.
  - Stall: op, rd, we, valid held. A register-sourced held operand whose stored address is nonzero and matches an asserted fwd1 or fwd2 source is overwritten with the forwarded value, using the same priority. Immediate- and shamt-sourced operands are never patched.
  - Load, `in_valid`=1: capture resolved operands, `in_op`, `in_rd_addr`, `in_we`, `ex_valid`=1.
  - Load, `in_valid`=0: capture a bubble, identical to the flush values.
- `ex_we` is never 1 while `ex_valid` is 0.
- Writes to r0 are passed through with `ex_we` as given. Consumers ignore them; this stage never forwards them because of the addr == 0 rule.

## Timing
- All outputs are registered; latency is 1 cycle from inputs to `alu_*`/`ex_*`.
- No combinational path from any input to any output.
- Forward values are sampled in the same cycle as the load or patch.
- Back-to-back dependency (producer now in EX, consumer in decode) resolves through fwd1 with zero stall. The upstream stage handles load-use stalls.
- Reset deasserted mid-stream: the first edge with `rst_n`=1 performs a normal load.
- Stall held N cycles: outputs stable except patched operands. Deasserting `stall` loads the next input on the following edge.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0 for 2 cycles with `in_valid`=1 and `in_op`=4.
  - Required: all outputs 0 after each edge.
- Forward priority:
  - Stimulus: rs=3, rf=0x11, fwd2 (rd 3, 0x22), fwd1 (rd 3, 0x33).
  - Required: `alu_a`=0x33.
  - Then drop fwd1: required `alu_a`=0x22.
  - Then rs=0 with all forwards on r0: required `alu_a`=0.
- Immediate and shamt:
  - Stimulus: imm=0x8001, sext=1.
  - Required: `alu_b`=0xFFFF8001.
  - With sext=0: required `alu_b`=0x00008001.
  - SLL with shamt=4, rt=0x1: required `alu_a`=4, `alu_b`=1, `alu_op`=7.
- Stall patch:
  - Stimulus: load ADD with rt=5 (rf 0x10), then stall 3 cycles. In stall cycle 2 assert fwd2 (rd 5, 0x99).
  - Required: `alu_b`=0x99 from the next edge onward, op still 4.
  - Immediate B is unchanged under the same forward.
- Flush vs stall:
  - Stimulus: assert `flush`=`stall`=1 with a valid instruction held.
  - Required: `ex_valid`=0, `ex_we`=0, `alu_a`=`alu_b`=0 next cycle.
- Bubble:
  - Stimulus: `in_valid`=0 with `in_we`=1.
  - Required: `ex_valid`=0, `ex_we`=0.
